rf_write_arbiter: RTL and testbench

//   Sole driver of the register-file write port (we3/a3/wd3, written on negedge clk).

---
 rtl/rf_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with queued long-latency writes.
// Optional pending-destination scoreboard is built when RF_SCOREBOARD_EN is defined.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p_valid,
    input  logic [4:0]               p_rd,
    input  logic [31:0]              p_data,
    output logic                     p_stall,
    input  logic                     l_valid,
    output logic                     l_ready,
    input  logic [4:0]               l_rd,
    input  logic [31:0]              l_data,
    input  logic                     sb_set,
    input  logic [4:0]               sb_rd,
    output logic [31:0]              busy,
    output logic                     rf_we,
    output logic [4:0]               rf_a,
    output logic [31:0]              rf_wd,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic          p_stall_reg, p_stall_next;
    logic          proto_err_reg;
    logic          rf_we_reg;
    logic [4:0]    rf_a_reg;
    logic [31:0]   rf_wd_reg;

    logic          p_req, fifo_ne, pop, push, store;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // Occupancy is registered, so a full FIFO refuses a push even when it pops this cycle.
    assign l_ready = rst_n & (cnt_reg < CW'(DEPTH));

    always_comb begin
        p_req     = p_valid & (p_rd != 5'd0);
        fifo_ne   = (cnt_reg != '0);
        pop       = fifo_ne & (p_stall_reg | ~p_req);
        push      = l_valid & l_ready;
        store     = push & (l_rd != 5'd0);
        head_rd   = mem_rd[rd_ptr_reg];
        head_data = mem_data[rd_ptr_reg];
        cnt_next  = cnt_reg + CW'(store) - CW'(pop);
    end

    // Starvation counter: counts waiting cycles of a non-empty FIFO; a stall forces the next pop.
    always_comb begin
        starve_next = '0;
        if (fifo_ne && !pop) begin
            if (starve_reg == SW'(STARVE_LIMIT))
                starve_next = starve_reg;
            else
                starve_next = starve_reg + SW'(1);
        end
        p_stall_next = (starve_next == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_rd[wr_ptr_reg]   <= l_rd;
            mem_data[wr_ptr_reg] <= l_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            starve_reg  <= '0;
            p_stall_reg <= 1'b0;
        end else begin
            if (store)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            cnt_reg     <= cnt_next;
            starve_reg  <= starve_next;
            p_stall_reg <= p_stall_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg     <= 1'b0;
            rf_a_reg      <= 5'd0;
            rf_wd_reg     <= 32'd0;
            proto_err_reg <= 1'b0;
        end else begin
            if (pop) begin
                rf_we_reg <= 1'b1;
                rf_a_reg  <= head_rd;
                rf_wd_reg <= head_data;
            end else if (p_req) begin
                rf_we_reg <= 1'b1;
                rf_a_reg  <= p_rd;
                rf_wd_reg <= p_data;
            end else begin
                rf_we_reg <= 1'b0;
            end
            if (p_valid && p_stall_reg)
                proto_err_reg <= 1'b1;
        end
    end

    assign p_stall   = p_stall_reg;
    assign proto_err = proto_err_reg;
    assign rf_we     = rf_we_reg;
    assign rf_a      = rf_a_reg;
    assign rf_wd     = rf_wd_reg;
    assign fifo_cnt  = cnt_reg;

`ifdef RF_SCOREBOARD_EN
    genvar gi;
    assign busy[0] = 1'b0;
    // One flop per architectural register; an issue-side set outranks a same-edge pop clear.
    for (gi = 1; gi < 32; gi++) begin : g_busy
        logic bit_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                bit_reg <= 1'b0;
            else if (sb_set && (sb_rd == 5'(gi)))
                bit_reg <= 1'b1;
            else if (pop && (head_rd == 5'(gi)))
                bit_reg <= 1'b0;
        end
        assign busy[gi] = bit_reg;
    end
`else
    logic sb_unused;
    assign busy      = 32'd0;
    assign sb_unused = &{1'b0, sb_set, sb_rd};
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table plus hand-written reset and starvation sequences.
module tb_rf_write_arbiter;

`ifdef RF_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid, l_valid, sb_set;
    logic [4:0]  p_rd, l_rd, sb_rd;
    logic [31:0] p_data, l_data;
    logic        p_stall, l_ready, rf_we, proto_err;
    logic [31:0] busy, rf_wd;
    logic [4:0]  rf_a;
    logic [2:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .sb_set(sb_set), .sb_rd(sb_rd), .busy(busy),
        .rf_we(rf_we), .rf_a(rf_a), .rf_wd(rf_wd),
        .fifo_cnt(fifo_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ss;
        logic [4:0]  srd;
        logic        we;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic        lr;
        logic        st;
        logic [31:0] bz;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] eb(input logic [31:0] m);
        return SB_EN ? m : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic ss, input logic [4:0] srd,
                       input logic we, input logic [4:0] a, input logic [31:0] wd,
                       input logic [2:0] cnt, input logic lr, input logic st, input logic [31:0] bz);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pd = pd; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.ss = ss; v.srd = srd; v.we = we; v.a = a; v.wd = wd; v.cnt = cnt;
        v.lr = lr; v.st = st; v.bz = bz;
        vq.push_back(v);
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic ss, input logic [4:0] srd);
        p_valid = pv; p_rd = prd; p_data = pd;
        l_valid = lv; l_rd = lrd; l_data = ld;
        sb_set = ss; sb_rd = srd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Table: p rd5 write, rd0 ignored, set/clear scoreboard, fill to full, starvation, drain.
        add(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,  1, 5, 32'hDEADBEEF, 0, 1, 0, 0);
        add(1, 0, 32'h1234,     0, 0, 0, 0, 0,  0, 5, 32'hDEADBEEF, 0, 1, 0, 0);
        add(0, 0, 0,            0, 0, 0, 1, 7,  0, 5, 32'hDEADBEEF, 0, 1, 0, eb(32'h80));
        add(1, 3, 32'h33,       1, 7, 32'h77, 0, 0, 1, 3, 32'h33, 1, 1, 0, eb(32'h80));
        add(0, 0, 0,            0, 0, 0, 0, 0,  1, 7, 32'h77, 0, 1, 0, 0);
        add(0, 0, 0,            0, 0, 0, 0, 0,  0, 7, 32'h77, 0, 1, 0, 0);
        add(1, 1, 32'h101, 1, 10, 32'hA0, 0, 0, 1, 1, 32'h101, 1, 1, 0, 0);
        add(1, 2, 32'h102, 1, 11, 32'hA1, 0, 0, 1, 2, 32'h102, 2, 1, 0, 0);
        add(1, 3, 32'h103, 1, 12, 32'hA2, 0, 0, 1, 3, 32'h103, 3, 1, 0, 0);
        add(1, 4, 32'h104, 1, 13, 32'hA3, 0, 0, 1, 4, 32'h104, 4, 0, 1, 0);
        add(0, 0, 0,       1, 14, 32'hA4, 0, 0, 1, 10, 32'hA0, 3, 1, 0, 0);
        add(0, 0, 0,       1, 14, 32'hA4, 0, 0, 1, 11, 32'hA1, 3, 1, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0,       1, 12, 32'hA2, 2, 1, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0,       1, 13, 32'hA3, 1, 1, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0,       1, 14, 32'hA4, 0, 1, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0,       0, 14, 32'hA4, 0, 1, 0, 0);
        add(0, 0, 0,       1, 0, 32'hFF, 0, 0,  0, 14, 32'hA4, 0, 1, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0,       0, 14, 32'hA4, 0, 1, 0, 0);
        add(0, 0, 0,       0, 0, 0, 1, 9,       0, 14, 32'hA4, 0, 1, 0, eb(32'h200));
        add(1, 20, 32'h2020, 1, 9, 32'h99, 0, 0, 1, 20, 32'h2020, 1, 1, 0, eb(32'h200));
        add(0, 0, 0,       0, 0, 0, 1, 9,       1, 9, 32'h99, 0, 1, 0, eb(32'h200));
        add(0, 0, 0,       0, 0, 0, 1, 0,       0, 9, 32'h99, 0, 1, 0, eb(32'h200));
        add(0, 0, 0,       1, 9, 32'h98, 0, 0,  0, 9, 32'h99, 1, 1, 0, eb(32'h200));
        add(0, 0, 0,       0, 0, 0, 0, 0,       1, 9, 32'h98, 0, 1, 0, 0);

        // Reset state while held
        tick();
        tick();
        chk("rst rf_we", 32'(rf_we), 0);
        chk("rst rf_a", 32'(rf_a), 0);
        chk("rst rf_wd", rf_wd, 0);
        chk("rst fifo_cnt", 32'(fifo_cnt), 0);
        chk("rst l_ready", 32'(l_ready), 0);
        chk("rst busy", busy, 0);
        chk("rst p_stall", 32'(p_stall), 0);
        chk("rst proto_err", 32'(proto_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel l_ready", 32'(l_ready), 1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].pv, vq[i].prd, vq[i].pd, vq[i].lv, vq[i].lrd, vq[i].ld, vq[i].ss, vq[i].srd);
            tick();
            chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(vq[i].we));
            chk($sformatf("v%0d rf_a", i), 32'(rf_a), 32'(vq[i].a));
            chk($sformatf("v%0d rf_wd", i), rf_wd, vq[i].wd);
            chk($sformatf("v%0d fifo_cnt", i), 32'(fifo_cnt), 32'(vq[i].cnt));
            chk($sformatf("v%0d l_ready", i), 32'(l_ready), 32'(vq[i].lr));
            chk($sformatf("v%0d p_stall", i), 32'(p_stall), 32'(vq[i].st));
            chk($sformatf("v%0d busy", i), busy, vq[i].bz);
            chk($sformatf("v%0d proto_err", i), 32'(proto_err), 0);
            $display("vec %0d: rf_we=%0d rf_a=%0d rf_wd=%08h cnt=%0d stall=%0d busy=%08h",
                     i, rf_we, rf_a, rf_wd, fifo_cnt, p_stall, busy);
        end

        // Starvation with a well-behaved pipeline bubble
        drive(1, 1, 32'h1, 1, 21, 32'h2121, 0, 0);
        tick();
        chk("st1 cnt", 32'(fifo_cnt), 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(k + 2), 32'(k + 2), 0, 0, 0, 0, 0);
            tick();
            chk($sformatf("st1 wait%0d rf_a", k), 32'(rf_a), 32'(k + 2));
            chk($sformatf("st1 wait%0d p_stall", k), 32'(p_stall), (k == 2) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("st1 head rf_a", 32'(rf_a), 21);
        chk("st1 head rf_wd", rf_wd, 32'h2121);
        chk("st1 p_stall", 32'(p_stall), 0);
        chk("st1 proto_err", 32'(proto_err), 0);
        $display("starve run 1: rf_a=%0d rf_wd=%08h proto_err=%0d", rf_a, rf_wd, proto_err);

        // Starvation with pipeline ignoring the stall
        drive(1, 1, 32'h1, 1, 22, 32'h2222, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(k + 2), 32'(k + 2), 0, 0, 0, 0, 0);
            tick();
        end
        chk("st2 p_stall", 32'(p_stall), 1);
        drive(1, 5, 32'h55, 0, 0, 0, 0, 0);
        tick();
        chk("st2 head rf_a", 32'(rf_a), 22);
        chk("st2 head rf_wd", rf_wd, 32'h2222);
        chk("st2 proto_err", 32'(proto_err), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("st2 sticky proto_err", 32'(proto_err), 1);
        chk("st2 idle rf_we", 32'(rf_we), 0);
        $display("starve run 2: rf_a=%0d proto_err=%0d", rf_a, proto_err);

        // Asynchronous reset with two queued entries
        drive(1, 1, 32'h1, 1, 23, 32'h23, 1, 23);
        tick();
        drive(1, 2, 32'h2, 1, 24, 32'h24, 1, 24);
        tick();
        chk("q2 fifo_cnt", 32'(fifo_cnt), 2);
        chk("q2 busy", busy, eb(32'h0180_0000));
        rst_n = 1'b0;
        #1;
        chk("arst rf_we", 32'(rf_we), 0);
        chk("arst fifo_cnt", 32'(fifo_cnt), 0);
        chk("arst busy", busy, 0);
        chk("arst l_ready", 32'(l_ready), 0);
        chk("arst proto_err", 32'(proto_err), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst rel l_ready", 32'(l_ready), 1);
        tick();
        chk("arst discard rf_we", 32'(rf_we), 0);
        chk("arst discard cnt", 32'(fifo_cnt), 0);
        $display("reset run: rf_we=%0d cnt=%0d busy=%08h", rf_we, fifo_cnt, busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
